info_fifo: RTL and testbench

- Parametrised successor to the single-register image-info latch.
- Queues up to DEPTH image descriptors (width, height, valid, next_column, next_image) written by the HDMI-side frame parser.
- Releases one descriptor per swap request from the matrix-side double buffer.
- Adds occupancy reporting, a selectable overflow policy, sticky overflow/drop accounting, and pulse-style event outputs.

---
 rtl/info_fifo.sv | 178 +++++++++++++++++
 tb/tb_info_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/info_fifo.sv
//------------------------------------------------------------------------------
// info_fifo : queue of image descriptors between the HDMI frame parser and the
//             matrix-side double buffer. One descriptor is released per swap.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module info_fifo #(
  parameter  int MAX_WIDTH  = 1920,
  parameter  int MAX_HEIGHT = 1080,
  parameter  int DEPTH      = 4,
  parameter  int OVERWRITE  = 0,
  parameter  int CNT_W      = 8,
  localparam int WW         = $clog2(MAX_WIDTH),
  localparam int HW         = $clog2(MAX_HEIGHT),
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_wr_en,
  input  logic [WW-1:0]    I_image_width,
  input  logic [HW-1:0]    I_image_height,
  input  logic             I_image_valid,
  input  logic             I_next_column,
  input  logic             I_next_image,
  input  logic             I_swap_trigger,
  input  logic             I_clr_overflow,
  output logic [WW-1:0]    O_image_width,
  output logic [HW-1:0]    O_image_height,
  output logic             O_image_valid,
  output logic             O_next_column,
  output logic             O_next_image,
  output logic             O_update,
  output logic [LW-1:0]    O_level,
  output logic             O_empty,
  output logic             O_full,
  output logic             O_overflow,
  output logic [CNT_W-1:0] O_drop_count
);

  localparam int            PW           = $clog2(DEPTH);
  localparam logic [LW-1:0] c_full_level = LW'(DEPTH);

  typedef struct packed {
    logic [WW-1:0] width;
    logic [HW-1:0] height;
    logic          valid;
    logic          col;
    logic          img;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [WW-1:0]    width_q, width_d;
  logic [HW-1:0]    height_q, height_d;
  logic             valid_q, valid_d;
  logic             col_q, col_d;
  logic             img_q, img_d;
  logic             update_q, update_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic   is_full;
  logic   pop_ok;
  logic   push_ok;
  logic   ovf_evt;
  entry_t rd_entry;
  entry_t wr_entry;

  always_comb begin
    is_full  = (level_q == c_full_level);
    pop_ok   = I_swap_trigger && (level_q != '0);
    // A pop on the same edge frees a slot, so only an unpaired full write overflows.
    ovf_evt  = I_wr_en && is_full && !I_swap_trigger;
    push_ok  = I_wr_en && (!is_full || pop_ok || (OVERWRITE != 0));
    rd_entry = mem_q[rd_ptr_q];
    wr_entry = '{width: I_image_width, height: I_image_height, valid: I_image_valid,
                 col: I_next_column, img: I_next_image};

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = (pop_ok || (ovf_evt && (OVERWRITE != 0))) ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push_ok && !pop_ok && !ovf_evt) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LW'(1);
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == c_full_level);

    width_d  = width_q;
    height_d = height_q;
    valid_d  = valid_q;
    if (pop_ok) begin
      width_d  = rd_entry.width;
      height_d = rd_entry.height;
      valid_d  = rd_entry.valid;
    end
    col_d    = pop_ok && rd_entry.col;
    img_d    = pop_ok && rd_entry.img;
    update_d = pop_ok;

    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (ovf_evt) begin
      overflow_d = 1'b1;
      if (I_clr_overflow) begin
        drop_d = CNT_W'(1);
      end else if (drop_q != '1) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end else if (I_clr_overflow) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      valid_q    <= 1'b0;
      col_q      <= 1'b0;
      img_q      <= 1'b0;
      update_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      width_q    <= width_d;
      height_q   <= height_d;
      valid_q    <= valid_d;
      col_q      <= col_d;
      img_q      <= img_d;
      update_q   <= update_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage carries no reset; entries are only observed after being written.
  always_ff @(posedge I_clk) begin
    if (push_ok && !I_rst) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign O_image_width  = width_q;
  assign O_image_height = height_q;
  assign O_image_valid  = valid_q;
  assign O_next_column  = col_q;
  assign O_next_image   = img_q;
  assign O_update       = update_q;
  assign O_level        = level_q;
  assign O_empty        = empty_q;
  assign O_full         = full_q;
  assign O_overflow     = overflow_q;
  assign O_drop_count   = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_info_fifo.sv
//------------------------------------------------------------------------------
// tb_info_fifo : drives a drop-policy (CNT_W=2) and an overwrite-policy
//                instance with identical stimulus; descriptors are scoreboarded.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_info_fifo;

  logic        clk = 1'b0;
  logic        rst, wr_en, valid_in, col_in, img_in, swap, clr;
  logic [10:0] w_in, h_in;

  logic [10:0] w0, h0, w1, h1;
  logic        v0, c0, i0, u0, e0, f0, o0;
  logic        v1, c1, i1, u1, e1, f1, o1;
  logic [2:0]  l0, l1;
  logic [1:0]  d0;
  logic [7:0]  d1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int w; int h; bit v; bit c; bit i;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  info_fifo #(.DEPTH(4), .OVERWRITE(0), .CNT_W(2)) u_drop (
    .I_clk(clk), .I_rst(rst), .I_wr_en(wr_en), .I_image_width(w_in),
    .I_image_height(h_in), .I_image_valid(valid_in), .I_next_column(col_in),
    .I_next_image(img_in), .I_swap_trigger(swap), .I_clr_overflow(clr),
    .O_image_width(w0), .O_image_height(h0), .O_image_valid(v0),
    .O_next_column(c0), .O_next_image(i0), .O_update(u0), .O_level(l0),
    .O_empty(e0), .O_full(f0), .O_overflow(o0), .O_drop_count(d0));

  info_fifo #(.DEPTH(4), .OVERWRITE(1), .CNT_W(8)) u_ovr (
    .I_clk(clk), .I_rst(rst), .I_wr_en(wr_en), .I_image_width(w_in),
    .I_image_height(h_in), .I_image_valid(valid_in), .I_next_column(col_in),
    .I_next_image(img_in), .I_swap_trigger(swap), .I_clr_overflow(clr),
    .O_image_width(w1), .O_image_height(h1), .O_image_valid(v1),
    .O_next_column(c1), .O_next_image(i1), .O_update(u1), .O_level(l1),
    .O_empty(e1), .O_full(f1), .O_overflow(o1), .O_drop_count(d1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cb(input string name, input logic [31:0] a0, input logic [31:0] a1,
                    input logic [31:0] exp);
    chk({"drop ", name}, a0, exp);
    chk({"ovr ", name}, a1, exp);
  endtask

  function automatic exp_t mk(input int w, input int h, input bit v, input bit c, input bit i);
    exp_t e;
    e.w = w; e.h = h; e.v = v; e.c = c; e.i = i;
    return e;
  endfunction

  function automatic exp_t mk1(input int w);
    return mk(w, w + 5, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic step(input bit wr, input int w, input int h, input bit v, input bit c,
                      input bit im, input bit sw, input bit cl, input bit rs);
    wr_en = wr; w_in = 11'(w); h_in = 11'(h); valid_in = v; col_in = c; img_in = im;
    swap = sw; clr = cl; rst = rs;
    @(posedge clk);
    #1;
    wr_en = 0; w_in = '0; h_in = '0; valid_in = 0; col_in = 0; img_in = 0;
    swap = 0; clr = 0; rst = 0;
  endtask

  task automatic push(input int w);
    step(1, w, w + 5, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pop2(input exp_t ea, input exp_t eb);
    q0.push_back(ea);
    q1.push_back(eb);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: every presented descriptor is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (u0) begin
      if (q0.size() == 0) begin
        chk("drop unexpected update", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("drop width", w0, e.w);
        chk("drop height", h0, e.h);
        chk("drop valid", v0, e.v);
        chk("drop next_column", c0, e.c);
        chk("drop next_image", i0, e.i);
      end
    end else begin
      chk("drop idle pulses", {c0, i0}, 0);
    end
    if (u1) begin
      if (q1.size() == 0) begin
        chk("ovr unexpected update", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("ovr width", w1, e.w);
        chk("ovr height", h1, e.h);
        chk("ovr valid", v1, e.v);
        chk("ovr next_column", c1, e.c);
        chk("ovr next_image", i1, e.i);
      end
    end else begin
      chk("ovr idle pulses", {c1, i1}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; wr_en = 0; w_in = '0; h_in = '0; valid_in = 0; col_in = 0; img_in = 0;
    swap = 0; clr = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cb("reset level", l0, l1, 0);
    cb("reset empty", e0, e1, 1);
    cb("reset full", f0, f1, 0);
    cb("reset overflow", o0, o1, 0);
    cb("reset drop", d0, d1, 0);
    cb("reset width", w0, w1, 0);
    cb("reset update", u0, u1, 0);

    // Single descriptor round trip with a one-cycle next_image pulse.
    step(1, 640, 480, 1, 0, 1, 0, 0, 0);
    cb("t1 level", l0, l1, 1);
    cb("t1 empty", e0, e1, 0);
    pop2(mk(640, 480, 1, 0, 1), mk(640, 480, 1, 0, 1));
    cb("t1 update", u0, u1, 1);
    cb("t1 next_image", i0, i1, 1);
    cb("t1 level after pop", l0, l1, 0);
    idle();
    cb("t1 next_image drops", i0, i1, 0);
    cb("t1 width held", w0, w1, 640);

    // Fill, drain in order, then pop while empty.
    push(10);
    step(1, 20, 25, 1, 1, 0, 0, 0, 0);
    push(30);
    push(40);
    cb("t2 full", f0, f1, 1);
    cb("t2 level", l0, l1, 4);
    pop2(mk1(10), mk1(10));
    pop2(mk(20, 25, 1, 1, 0), mk(20, 25, 1, 1, 0));
    pop2(mk1(30), mk1(30));
    pop2(mk1(40), mk1(40));
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cb("t2 empty-pop update", u0, u1, 0);
    cb("t2 empty-pop width", w0, w1, 40);
    cb("t2 empty-pop level", l0, l1, 0);

    // Push while full: drop newest versus overwrite oldest.
    push(10); push(20); push(30); push(40); push(50);
    cb("t3 overflow", o0, o1, 1);
    cb("t3 drop", d0, d1, 1);
    cb("t3 level", l0, l1, 4);
    pop2(mk1(10), mk1(20));
    pop2(mk1(20), mk1(30));
    pop2(mk1(30), mk1(40));
    pop2(mk1(40), mk1(50));
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cb("t3 clr overflow", o0, o1, 0);
    cb("t3 clr drop", d0, d1, 0);

    // Simultaneous push and pop on an empty queue stores only.
    step(1, 100, 105, 1, 0, 0, 1, 0, 0);
    cb("t4 level", l0, l1, 1);
    cb("t4 update", u0, u1, 0);
    chk("drop t4 width held", w0, 40);
    chk("ovr t4 width held", w1, 50);
    pop2(mk1(100), mk1(100));

    // Simultaneous push and pop on a full queue.
    push(11); push(12); push(13); push(14);
    q0.push_back(mk1(11));
    q1.push_back(mk1(11));
    step(1, 60, 65, 1, 0, 0, 1, 0, 0);
    cb("t5 level", l0, l1, 4);
    cb("t5 full", f0, f1, 1);
    cb("t5 overflow", o0, o1, 0);
    cb("t5 update", u0, u1, 1);
    pop2(mk1(12), mk1(12));
    pop2(mk1(13), mk1(13));
    pop2(mk1(14), mk1(14));
    pop2(mk1(60), mk1(60));

    // Pointer wrap.
    for (int k = 1; k <= 10; k++) begin
      push(k);
      pop2(mk1(k), mk1(k));
    end
    cb("t6 level", l0, l1, 0);

    // Reset mid-burst with a concurrent push.
    push(200);
    push(201);
    step(1, 202, 207, 1, 1, 1, 0, 0, 1);
    cb("t7 level", l0, l1, 0);
    cb("t7 empty", e0, e1, 1);
    cb("t7 full", f0, f1, 0);
    cb("t7 width", w0, w1, 0);
    cb("t7 height", h0, h1, 0);
    cb("t7 valid", v0, v1, 0);
    cb("t7 update", u0, u1, 0);

    // Drop-counter saturation, then clear racing an overflow event.
    push(1); push(2); push(3); push(4);
    for (int k = 71; k <= 75; k++) push(k);
    chk("drop t8 saturated", d0, 3);
    chk("ovr t8 count", d1, 5);
    cb("t8 overflow", o0, o1, 1);
    cb("t8 level", l0, l1, 4);
    step(1, 76, 81, 1, 0, 0, 0, 1, 0);
    cb("t8 clr+event drop", d0, d1, 1);
    cb("t8 clr+event overflow", o0, o1, 1);
    pop2(mk1(1), mk1(73));
    pop2(mk1(2), mk1(74));
    pop2(mk1(3), mk1(75));
    pop2(mk1(4), mk1(76));
    idle();
    idle();
    cb("t8 level", l0, l1, 0);
    chk("drop scoreboard drained", q0.size(), 0);
    chk("ovr scoreboard drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
